// File: rtl/sdram_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
package sdram_pkg;

  localparam int MAX_PORTS    = 8;
  localparam int MAX_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // A write whose byte enables are all clear moves no data.
  function automatic logic be_is_null(input logic [MAX_BE_WIDTH-1:0] be);
    return (be == '0);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: one-hot grant to the first requester after 'last'.
module rr_arbiter #(
  parameter int N = 4,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic        found;
  int unsigned idx;

  // Scan from last+1 upward, wrapping, and grant the first active request.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = (32'(last) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port among NUM_PORTS requesters,
// one transaction in flight, with completions routed to the owning port.
module sdram_port_arbiter
  import sdram_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             p_valid,
  output logic [NUM_PORTS-1:0]             p_ready,
  input  logic [NUM_PORTS-1:0]             p_rd,
  input  logic [NUM_PORTS*BE_WIDTH-1:0]    p_be,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
  output logic [NUM_PORTS-1:0]             p_rvalid,
  output logic [NUM_PORTS-1:0]             p_wdone,
  output logic [DATA_WIDTH-1:0]            p_rdata,
  output logic                             m_rd,
  output logic [BE_WIDTH-1:0]              m_wr,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_rdy,
  input  logic                             m_rvalid,
  input  logic                             m_wvalid,
  input  logic [DATA_WIDTH-1:0]            m_rdata
);

  localparam int IW = $clog2(NUM_PORTS);

  arb_state_e state, state_nx;

  logic [NUM_PORTS-1:0]  grant;
  logic [IW-1:0]         last_grant;
  logic                  accept;
  logic                  done;
  logic                  hold_null;

  logic                  sel_rd;
  logic [BE_WIDTH-1:0]   sel_be;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [IW-1:0]         sel_idx;

  logic                  hold_rd;
  logic [BE_WIDTH-1:0]   hold_be;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic [IW-1:0]         hold_idx;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req   (p_valid),
    .last  (last_grant),
    .grant (grant)
  );

  // Pick out the fields of the granted port.
  always_comb begin
    sel_rd    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) begin
        sel_rd    = p_rd[i];
        sel_be    = p_be[i*BE_WIDTH +: BE_WIDTH];
        sel_addr  = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_idx   = IW'(i);
      end
    end
  end

  assign accept    = (state == IDLE) && (|grant) && !rst;
  // Null writes bypass ISSUE and complete on their own from WAIT.
  assign hold_null = !hold_rd && be_is_null(MAX_BE_WIDTH'(hold_be));
  assign done      = hold_rd ? m_rvalid : (m_wvalid || hold_null);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nx = (!sel_rd && be_is_null(MAX_BE_WIDTH'(sel_be))) ? WAIT : ISSUE;
      end
      ISSUE: if (m_rdy) state_nx = WAIT;
      WAIT:  if (done)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Hold registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_rd    <= 1'b0;
      hold_be    <= '0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_idx   <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
    end else begin
      if (accept) begin
        hold_rd    <= sel_rd;
        hold_be    <= sel_be;
        hold_addr  <= sel_addr;
        hold_wdata <= sel_wdata;
        hold_idx   <= sel_idx;
      end
      if (state == WAIT && done) last_grant <= hold_idx;
    end
  end

  // Outputs: ready in IDLE, command in ISSUE, completion demux in WAIT.
  always_comb begin
    p_ready  = '0;
    p_rvalid = '0;
    p_wdone  = '0;
    p_rdata  = '0;
    m_rd     = 1'b0;
    m_wr     = '0;
    m_addr   = '0;
    m_wdata  = '0;
    if (!rst) begin
      unique case (state)
        IDLE: p_ready = grant;
        ISSUE: begin
          m_rd    = hold_rd;
          m_wr    = hold_rd ? '0 : hold_be;
          m_addr  = hold_addr;
          m_wdata = hold_wdata;
        end
        WAIT: begin
          if (hold_rd && m_rvalid) begin
            p_rvalid[hold_idx] = 1'b1;
            p_rdata            = m_rdata;
          end else if (!hold_rd && (m_wvalid || hold_null)) begin
            p_wdone[hold_idx] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (4 ports, 24-bit addr, 16-bit data).
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     p_valid, p_ready, p_rd, p_rvalid, p_wdone;
  logic [NP*BW-1:0]  p_be;
  logic [NP*AW-1:0]  p_addr;
  logic [NP*DW-1:0]  p_wdata;
  logic [DW-1:0]     p_rdata;
  logic              m_rd;
  logic [BW-1:0]     m_wr;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_rdy, m_rvalid, m_wvalid;
  logic [DW-1:0]     m_rdata;

  int checks = 0;
  int errors = 0;

  sdram_port_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_rd    (p_rd),
    .p_be    (p_be),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .p_rvalid(p_rvalid),
    .p_wdone (p_wdone),
    .p_rdata (p_rdata),
    .m_rd    (m_rd),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdy   (m_rdy),
    .m_rvalid(m_rvalid),
    .m_wvalid(m_wvalid),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    p_valid  = '0;
    p_rd     = '0;
    p_be     = '0;
    p_addr   = '0;
    p_wdata  = '0;
    m_rdy    = 1'b1;
    m_rvalid = 1'b0;
    m_wvalid = 1'b0;
    m_rdata  = '0;
    tick();
    tick();
    chk("rst_p_ready", 32'(p_ready), 32'h0);
    chk("rst_m_rd", 32'(m_rd), 32'h0);
    chk("rst_m_wr", 32'(m_wr), 32'h0);
    chk("rst_m_addr", 32'(m_addr), 32'h0);
    chk("rst_p_wdone", 32'(p_wdone), 32'h0);
    chk("rst_p_rvalid", 32'(p_rvalid), 32'h0);
    rst = 1'b0;

    // Round-robin: all four ports hold writes; expect 0,1,2,3,0.
    for (int i = 0; i < NP; i++) begin
      p_be[i*BW +: BW]      = 2'b11;
      p_addr[i*AW +: AW]    = AW'(32'h100 + 32'(i) * 32'h10);
      p_wdata[i*DW +: DW]   = DW'(32'hA000 + 32'(i));
    end
    p_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % NP;
      #1;
      chk("rr_ready", 32'(p_ready), 32'(1) << g);
      tick();
      chk("rr_m_wr", 32'(m_wr), 32'h3);
      chk("rr_m_addr", 32'(m_addr), 32'h100 + 32'(g) * 32'h10);
      chk("rr_m_wdata", 32'(m_wdata), 32'hA000 + 32'(g));
      tick();
      m_wvalid = 1'b1;
      #1;
      chk("rr_wdone", 32'(p_wdone), 32'(1) << g);
      tick();
      m_wvalid = 1'b0;
    end
    p_valid = '0;
    p_be    = '0;
    tick();

    // Single read from port 2, data after 5 cycles.
    p_valid = 4'b0100;
    p_rd    = 4'b0100;
    p_addr[2*AW +: AW] = 24'h000124;
    #1;
    chk("rd_ready", 32'(p_ready), 32'h4);
    tick();
    p_valid = '0;
    chk("rd_m_rd", 32'(m_rd), 32'h1);
    chk("rd_m_addr", 32'(m_addr), 32'h000124);
    chk("rd_m_wr", 32'(m_wr), 32'h0);
    tick();
    chk("rd_wait_m_rd", 32'(m_rd), 32'h0);
    for (int k = 0; k < 4; k++) tick();
    m_rvalid = 1'b1;
    m_rdata  = 16'hBEEF;
    #1;
    chk("rd_rvalid", 32'(p_rvalid), 32'h4);
    chk("rd_rdata", 32'(p_rdata), 32'hBEEF);
    chk("rd_no_wdone", 32'(p_wdone), 32'h0);
    tick();
    m_rvalid = 1'b0;
    p_rd     = '0;
    #1;
    chk("rd_rvalid_clear", 32'(p_rvalid), 32'h0);
    chk("rd_rdata_zero", 32'(p_rdata), 32'h0);

    // Controller busy: port 3 write held while m_rdy is low.
    m_rdy   = 1'b0;
    p_valid = 4'b1000;
    p_be[3*BW +: BW]   = 2'b01;
    p_addr[3*AW +: AW] = 24'h0ABCDE;
    #1;
    chk("busy_ready", 32'(p_ready), 32'h8);
    tick();
    p_valid = '0;
    for (int k = 0; k < 10; k++) begin
      chk("busy_m_wr", 32'(m_wr), 32'h1);
      chk("busy_m_addr", 32'(m_addr), 32'h0ABCDE);
      tick();
    end
    m_rdy = 1'b1;
    #1;
    chk("busy_take_m_wr", 32'(m_wr), 32'h1);
    tick();
    chk("busy_wait_m_wr", 32'(m_wr), 32'h0);
    m_wvalid = 1'b1;
    #1;
    chk("busy_wdone", 32'(p_wdone), 32'h8);
    tick();
    m_wvalid = 1'b0;
    p_be     = '0;

    // Null write on port 1: no command, wdone one cycle after accept.
    p_valid = 4'b0010;
    #1;
    chk("null_ready", 32'(p_ready), 32'h2);
    tick();
    p_valid = '0;
    chk("null_m_wr", 32'(m_wr), 32'h0);
    chk("null_m_rd", 32'(m_rd), 32'h0);
    chk("null_wdone", 32'(p_wdone), 32'h2);
    tick();
    chk("null_wdone_clear", 32'(p_wdone), 32'h0);

    // Completions while idle are ignored.
    m_rvalid = 1'b1;
    m_wvalid = 1'b1;
    m_rdata  = 16'h5555;
    #1;
    chk("idle_rvalid", 32'(p_rvalid), 32'h0);
    chk("idle_wdone", 32'(p_wdone), 32'h0);
    chk("idle_rdata", 32'(p_rdata), 32'h0);
    tick();
    m_rvalid = 1'b0;
    m_wvalid = 1'b0;

    // Read with be=11 on port 0; then both completions -> read wins.
    p_valid = 4'b0001;
    p_rd    = 4'b0001;
    p_be[0 +: BW] = 2'b11;
    p_addr[0 +: AW] = 24'h000042;
    tick();
    p_valid = '0;
    chk("rdbe_m_rd", 32'(m_rd), 32'h1);
    chk("rdbe_m_wr", 32'(m_wr), 32'h0);
    tick();
    m_rvalid = 1'b1;
    m_wvalid = 1'b1;
    m_rdata  = 16'h1234;
    #1;
    chk("both_rvalid", 32'(p_rvalid), 32'h1);
    chk("both_wdone", 32'(p_wdone), 32'h0);
    chk("both_rdata", 32'(p_rdata), 32'h1234);
    tick();
    m_rvalid = 1'b0;
    m_wvalid = 1'b0;
    p_rd     = '0;

    // Reset while waiting: no completion, pointer back to port 0.
    p_valid = 4'b0100;
    p_be[2*BW +: BW] = 2'b11;
    tick();
    p_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    m_rvalid = 1'b1;
    m_wvalid = 1'b1;
    #1;
    chk("rstw_rvalid", 32'(p_rvalid), 32'h0);
    chk("rstw_wdone", 32'(p_wdone), 32'h0);
    m_rvalid = 1'b0;
    m_wvalid = 1'b0;
    p_valid  = 4'b1111;
    #1;
    chk("rstw_ready_p0", 32'(p_ready), 32'h1);
    tick();
    p_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
